// File: rtl/ram_arbiter_pkg.sv
// Shared constants, state encodings and the range-check helper for the RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned IT_RAM_DEPTH   = 1024;
  localparam int unsigned DATA_RAM_DEPTH = 1024;
  localparam int unsigned StreakW        = 4;

  localparam logic        READ_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_32BIT   = 32'h0000_0000;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_CMD  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ARB_IDLE,
    StCmd  = ARB_CMD,
    StResp = ARB_RESP
  } arb_state_e;

  // Comparing against the last legal word start avoids forming addr+3, which could wrap.
  function automatic logic out_of_range(input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] last_word);
    return addr > last_word;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection: MEM priority with a bounded streak so IF cannot starve.
module arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic               if_req,
  input  logic               mem_req,
  input  logic [StreakW-1:0] streak,
  output logic               gnt_if,
  output logic               gnt_mem,
  output logic [StreakW-1:0] streak_next
);

  localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_MEM_STREAK);

  if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 15) begin : g_bad_streak
    $error("MAX_MEM_STREAK must be in 1..15");
  end

  logic if_starved;
  assign if_starved = if_req && (streak >= MaxStreak);

  always_comb begin
    gnt_if      = 1'b0;
    gnt_mem     = 1'b0;
    streak_next = streak;
    if (mem_req && !if_starved) begin
      gnt_mem = 1'b1;
      if (if_req && (streak < MaxStreak)) begin
        streak_next = streak + StreakW'(1);
      end
    end else if (if_req) begin
      gnt_if      = 1'b1;
      streak_next = '0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store with a 3-cycle
// IDLE/CMD/RESP sequence, bounded IF starvation and out-of-range rejection.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned RAM_BYTES      = IT_RAM_DEPTH + DATA_RAM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_done,
  output logic            if_err,
  output logic [XLEN-1:0] if_rdata,

  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            mem_done,
  output logic            mem_err,
  output logic [XLEN-1:0] mem_rdata,

  output logic            ram_en,
  output logic            ram_read_flag,
  output logic            ram_write_flag,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata
);

  localparam logic [XLEN-1:0] LastWord = XLEN'(RAM_BYTES - 4);

  arb_state_e         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d, streak_next;
  logic               sel_mem_q, sel_mem_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;

  logic               gnt_if, gnt_mem, grant;
  logic [XLEN-1:0]    pick_addr;
  logic [XLEN-1:0]    resp_rdata;

  arb_pick #(
    .MAX_MEM_STREAK (MAX_MEM_STREAK)
  ) u_arb_pick (
    .if_req      (if_req),
    .mem_req     (mem_req),
    .streak      (streak_q),
    .gnt_if      (gnt_if),
    .gnt_mem     (gnt_mem),
    .streak_next (streak_next)
  );

  // Requests are only looked at in IDLE; changes during CMD/RESP are ignored.
  assign grant     = (state_q == StIdle) && (gnt_if || gnt_mem);
  assign pick_addr = gnt_mem ? mem_addr : if_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StCmd;
      StCmd:   state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access latch and streak bookkeeping
  always_comb begin
    sel_mem_d = sel_mem_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    streak_d  = streak_q;
    if (grant) begin
      sel_mem_d = gnt_mem;
      we_d      = gnt_mem && mem_we;
      err_d     = out_of_range(pick_addr, LastWord);
      addr_d    = pick_addr;
      wdata_d   = gnt_mem ? mem_wdata : ZERO_32BIT;
      streak_d  = streak_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_mem_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      streak_q  <= '0;
    end else begin
      sel_mem_q <= sel_mem_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      streak_q  <= streak_d;
    end
  end

  // Output logic: RAM driven only in CMD, responses only in RESP
  always_comb begin
    ram_en         = 1'b0;
    ram_read_flag  = 1'b0;
    ram_write_flag = 1'b0;
    ram_addr       = ZERO_32BIT;
    ram_wdata      = ZERO_32BIT;
    if_done        = 1'b0;
    if_err         = 1'b0;
    if_rdata       = ZERO_32BIT;
    mem_done       = 1'b0;
    mem_err        = 1'b0;
    mem_rdata      = ZERO_32BIT;
    resp_rdata     = (!we_q && !err_q) ? ram_rdata : ZERO_32BIT;
    unique case (state_q)
      StCmd: begin
        if (!err_q) begin
          ram_en         = 1'b1;
          ram_write_flag = we_q ? WRITE_ENABLE : 1'b0;
          ram_read_flag  = we_q ? 1'b0 : READ_ENABLE;
          ram_addr       = addr_q;
          ram_wdata      = wdata_q;
        end
      end
      StResp: begin
        if (sel_mem_q) begin
          mem_done  = 1'b1;
          mem_err   = err_q;
          mem_rdata = resp_rdata;
        end else begin
          if_done  = 1'b1;
          if_err   = err_q;
          if_rdata = resp_rdata;
        end
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_ram_only_in_cmd: assert property (@(posedge clk) disable iff (rst)
    ram_en |-> (state_q == StCmd));
  a_single_done: assert property (@(posedge clk) disable iff (rst)
    !(if_done && mem_done));
  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ram_read_flag && ram_write_flag));
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed registered-read RAM model,
// plus a standalone table check of arb_pick.
module tb_ram_arbiter;

  localparam int unsigned RamBytes = 2048;

  logic        clk, rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_done, if_err, mem_done, mem_err;
  logic [31:0] if_rdata, mem_rdata;
  logic        ram_en, ram_read_flag, ram_write_flag;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        p_if, p_mem, p_gnt_if, p_gnt_mem;
  logic [3:0]  p_streak, p_streak_next;

  logic [7:0]  ram_mem [RamBytes];
  int          n_tests = 0;
  int          n_fail  = 0;

  ram_arbiter #(
    .MAX_MEM_STREAK (4),
    .RAM_BYTES      (RamBytes)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_err         (if_err),
    .if_rdata       (if_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_done       (mem_done),
    .mem_err        (mem_err),
    .mem_rdata      (mem_rdata),
    .ram_en         (ram_en),
    .ram_read_flag  (ram_read_flag),
    .ram_write_flag (ram_write_flag),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  arb_pick #(
    .MAX_MEM_STREAK (4)
  ) u_pick (
    .if_req      (p_if),
    .mem_req     (p_mem),
    .streak      (p_streak),
    .gnt_if      (p_gnt_if),
    .gnt_mem     (p_gnt_mem),
    .streak_next (p_streak_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian RAM: write commits and read data registers on the edge ending CMD.
  always @(posedge clk) begin
    if (ram_en && ram_write_flag) begin
      ram_mem[ram_addr[10:0]]         <= ram_wdata[7:0];
      ram_mem[ram_addr[10:0] + 11'd1] <= ram_wdata[15:8];
      ram_mem[ram_addr[10:0] + 11'd2] <= ram_wdata[23:16];
      ram_mem[ram_addr[10:0] + 11'd3] <= ram_wdata[31:24];
    end
    if (ram_en && ram_read_flag) begin
      ram_rdata <= {ram_mem[ram_addr[10:0] + 11'd3], ram_mem[ram_addr[10:0] + 11'd2],
                    ram_mem[ram_addr[10:0] + 11'd1], ram_mem[ram_addr[10:0]]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{if_done, if_err, if_rdata, mem_done, mem_err, mem_rdata,
             ram_en, ram_read_flag, ram_write_flag, ram_addr, ram_wdata};
  endfunction

  // One access issued from IDLE: CMD one edge later, done the edge after that.
  task automatic access(input string tag, input bit is_mem, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_err);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    step();
    check({tag, "_cmd_ctl"}, {29'd0, ram_en, ram_read_flag, ram_write_flag},
          exp_err ? 32'd0 : {29'd0, 1'b1, !we, we});
    if (!exp_err) check({tag, "_cmd_addr"}, ram_addr, addr);
    step();
    check({tag, "_done"}, {30'd0, if_done, mem_done}, is_mem ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, is_mem ? mem_rdata : if_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, is_mem ? mem_err : if_err}, {31'd0, exp_err});
    check({tag, "_resp_en"}, {31'd0, ram_en}, 32'd0);
    mem_req = 1'b0;
    if_req  = 1'b0;
    step();
  endtask

  // {if_req, mem_req, streak, gnt_if, gnt_mem, streak_next}
  logic [11:0] pick_vec [7] = '{
    {1'b0, 1'b0, 4'd2, 2'b00, 4'd2},
    {1'b1, 1'b0, 4'd3, 2'b10, 4'd0},
    {1'b0, 1'b1, 4'd2, 2'b01, 4'd2},
    {1'b1, 1'b1, 4'd2, 2'b01, 4'd3},
    {1'b1, 1'b1, 4'd3, 2'b01, 4'd4},
    {1'b1, 1'b1, 4'd4, 2'b10, 4'd0},
    {1'b0, 1'b1, 4'd4, 2'b01, 4'd4}
  };

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_rdata = '0;
    p_if = 1'b0; p_mem = 1'b0; p_streak = '0;
    for (int i = 0; i < int'(RamBytes); i++) ram_mem[i] = 8'h00;
    ram_mem[16'h10] = 8'h11; ram_mem[16'h11] = 8'h22;
    ram_mem[16'h12] = 8'h33; ram_mem[16'h13] = 8'h44;
    ram_mem[2044] = 8'h04; ram_mem[2045] = 8'h03;
    ram_mem[2046] = 8'h02; ram_mem[2047] = 8'h01;

    step();
    step();
    check("reset_outs", {31'd0, any_out()}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_outs", {31'd0, any_out()}, 32'd0);

    access("if_rd",    1'b0, 1'b0, 32'h10,  32'h0,         32'h4433_2211, 1'b0);
    access("mem_wr",   1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0,         1'b0);
    access("mem_rd",   1'b1, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF, 1'b0);
    access("last_rd",  1'b1, 1'b0, 32'd2044, 32'h0,        32'h0102_0304, 1'b0);
    access("oor_wr",   1'b1, 1'b1, 32'd2045, 32'h1234_5678, 32'h0,        1'b1);
    access("oor_if",   1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,   32'h0,         1'b1);
    access("after_oor", 1'b1, 1'b0, 32'd2044, 32'h0,       32'h0102_0304, 1'b0);

    // Held IF against continuous MEM traffic: 4 MEM grants then 1 IF, repeating.
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      step();
      step();
      check($sformatf("streak_%0d", k), {30'd0, if_done, mem_done},
            (k % 5 == 4) ? 32'd2 : 32'd1);
      step();
    end
    if_req = 1'b0; mem_req = 1'b0;

    // Reset while a MEM read sits in CMD.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    step();
    check("rst_cmd_pre", {31'd0, ram_en}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_cmd_outs", {31'd0, any_out()}, 32'd0);
    step();
    check("rst_no_done", {31'd0, mem_done}, 32'd0);
    #2 rst = 1'b0;
    step();
    check("rearb_cmd", {31'd0, ram_en}, 32'd1);
    step();
    check("rearb_done", {31'd0, mem_done}, 32'd1);
    check("rearb_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_req = 1'b0;
    step();

    // Simultaneous first requests after reset: MEM first, IF next.
    rst = 1'b1;
    #3 rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    step();
    step();
    check("simul_first", {30'd0, if_done, mem_done}, 32'd1);
    mem_req = 1'b0;
    step();
    step();
    step();
    check("simul_second", {30'd0, if_done, mem_done}, 32'd2);
    check("simul_if_rdata", if_rdata, 32'h4433_2211);
    if_req = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      {p_if, p_mem, p_streak} = pick_vec[v][11:6];
      #1;
      check($sformatf("pick_%0d", v), {26'd0, p_gnt_if, p_gnt_mem, p_streak_next},
            {26'd0, pick_vec[v][5:0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
